// File: rtl/ring_counter_monitor.sv
// Receive-side checker for a one-hot ring counter bus: decodes the hot stage,
// locks after LOCK_CNT correct advances, and flags/counts illegal steps while locked.
module ring_counter_monitor #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk_i,
  input  logic             sys_rst_i,
  input  logic [WIDTH-1:0] ring_i,
  input  logic             clr_err_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_valid_o,
  output logic             locked_o,
  output logic             err_o,
  output logic             wrap_o,
  output logic [7:0]       err_cnt_o
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       match_q, match_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             onehot;
  logic             adv;
  logic [IDX_W-1:0] idx_enc;

  // A value with exactly one bit set is nonzero and clears to zero when its lowest set bit is removed.
  assign onehot = (ring_i != '0) && ((ring_i & (ring_i - WIDTH'(1))) == '0);
  assign adv    = onehot && (ring_i == {prev_q[WIDTH-2:0], prev_q[WIDTH-1]});

  always_comb begin
    idx_enc = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (ring_i[k]) idx_enc = IDX_W'(k);
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = ring_i;
    match_d     = match_q;
    idx_d       = onehot ? idx_enc : idx_q;
    idx_valid_d = 1'b0;
    err_d       = 1'b0;
    wrap_d      = 1'b0;

    unique case (state_q)
      SEARCH: begin
        if (adv) begin
          if (match_q + 4'd1 == 4'(LOCK_CNT)) begin
            state_d     = LOCKED;
            match_d     = '0;
            idx_valid_d = 1'b1;
          end else begin
            match_d = match_q + 4'd1;
          end
        end else begin
          match_d = '0;
        end
      end
      LOCKED: begin
        if (adv) begin
          idx_valid_d = 1'b1;
          wrap_d      = prev_q[WIDTH-1] & ring_i[0];
        end else begin
          err_d   = 1'b1;
          state_d = SEARCH;
          match_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase

    if (clr_err_i) begin
      err_cnt_d = '0;
    end else if (err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q     <= SEARCH;
      prev_q      <= '0;
      match_q     <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign idx_o       = idx_q;
  assign idx_valid_o = idx_valid_q;
  assign locked_o    = (state_q == LOCKED);
  assign err_o       = err_q;
  assign wrap_o      = wrap_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_ring_counter_monitor.sv
// Table-driven bench for ring_counter_monitor: expected outputs are queued when
// a sample is driven and checked one edge later.
module tb_ring_counter_monitor;

  typedef struct {
    logic [7:0] ring;
    logic       clr;
    logic [2:0] idx;
    logic       valid;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ring;
  logic       clr;
  logic [2:0] idx_o;
  logic       idx_valid_o, locked_o, err_o, wrap_o;
  logic [7:0] err_cnt_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  ring_counter_monitor #(.WIDTH(8), .IDX_W(3), .LOCK_CNT(4)) dut (
    .clk_i      (clk),
    .sys_rst_i  (rst),
    .ring_i     (ring),
    .clr_err_i  (clr),
    .idx_o      (idx_o),
    .idx_valid_o(idx_valid_o),
    .locked_o   (locked_o),
    .err_o      (err_o),
    .wrap_o     (wrap_o),
    .err_cnt_o  (err_cnt_o)
  );

  function automatic vec_t mk(input logic [7:0] r, input logic c, input logic [2:0] i,
                              input logic v, input logic l, input logic e,
                              input logic w, input logic [7:0] n);
    vec_t t;
    t.ring = r; t.clr = c; t.idx = i; t.valid = v;
    t.locked = l; t.err = e; t.wrap = w; t.cnt = n;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    chk({tag, " idx"},    int'(idx_o),       int'(e.idx));
    chk({tag, " valid"},  int'(idx_valid_o), int'(e.valid));
    chk({tag, " locked"}, int'(locked_o),    int'(e.locked));
    chk({tag, " err"},    int'(err_o),       int'(e.err));
    chk({tag, " wrap"},   int'(wrap_o),      int'(e.wrap));
    chk({tag, " cnt"},    int'(err_cnt_o),   int'(e.cnt));
  endtask

  // Called in the low clock phase; drives, waits one edge, checks, returns at the next negedge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    ring = v.ring;
    clr  = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_all(tag, e);
    end
    @(negedge clk);
  endtask

  initial begin
    int unsigned c;

    //         ring   clr idx v  l  e  w  cnt
    tbl.push_back(mk(8'h01, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h02, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h04, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h08, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h10, 0, 4, 1, 1, 0, 0, 0));
    tbl.push_back(mk(8'h20, 0, 5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(8'h40, 0, 6, 1, 1, 0, 0, 0));
    tbl.push_back(mk(8'h80, 0, 7, 1, 1, 0, 0, 0));
    tbl.push_back(mk(8'h01, 0, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(8'h02, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(8'h04, 0, 2, 1, 1, 0, 0, 0));
    tbl.push_back(mk(8'h03, 0, 2, 0, 0, 1, 0, 1));
    tbl.push_back(mk(8'h04, 0, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h08, 0, 3, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h10, 0, 4, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h20, 0, 5, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h40, 0, 6, 1, 1, 0, 0, 1));
    tbl.push_back(mk(8'h80, 0, 7, 1, 1, 0, 0, 1));
    tbl.push_back(mk(8'h01, 0, 0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(8'h02, 0, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(8'h04, 0, 2, 1, 1, 0, 0, 1));
    tbl.push_back(mk(8'h08, 0, 3, 1, 1, 0, 0, 1));
    tbl.push_back(mk(8'h08, 0, 3, 0, 0, 1, 0, 2));
    tbl.push_back(mk(8'h08, 0, 3, 0, 0, 0, 0, 2));
    tbl.push_back(mk(8'h08, 0, 3, 0, 0, 0, 0, 2));
    tbl.push_back(mk(8'h10, 0, 4, 0, 0, 0, 0, 2));
    tbl.push_back(mk(8'h20, 0, 5, 0, 0, 0, 0, 2));
    tbl.push_back(mk(8'h40, 0, 6, 0, 0, 0, 0, 2));
    tbl.push_back(mk(8'h80, 0, 7, 1, 1, 0, 0, 2));
    tbl.push_back(mk(8'h40, 0, 6, 0, 0, 1, 0, 3));
    tbl.push_back(mk(8'h80, 0, 7, 0, 0, 0, 0, 3));
    tbl.push_back(mk(8'h01, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(8'h02, 0, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(8'h04, 0, 2, 1, 1, 0, 0, 3));
    tbl.push_back(mk(8'h00, 0, 2, 0, 0, 1, 0, 4));
    tbl.push_back(mk(8'h01, 1, 0, 0, 0, 0, 0, 0));

    rst  = 1'b1;
    ring = 8'h00;
    clr  = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", mk(8'h00, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // Drive the error counter through saturation: lock, then a zero-hot sample.
    c = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      step("sat_01", mk(8'h01, 0, 0, 0, 0, 0, 0, 8'(c)));
      step("sat_02", mk(8'h02, 0, 1, 0, 0, 0, 0, 8'(c)));
      step("sat_04", mk(8'h04, 0, 2, 0, 0, 0, 0, 8'(c)));
      step("sat_08", mk(8'h08, 0, 3, 0, 0, 0, 0, 8'(c)));
      step("sat_10", mk(8'h10, 0, 4, 1, 1, 0, 0, 8'(c)));
      if (c < 255) c++;
      step("sat_err", mk(8'h00, 0, 4, 0, 0, 1, 0, 8'(c)));
    end
    chk("sat_final", int'(err_cnt_o), 255);

    step("clr_01", mk(8'h01, 0, 0, 0, 0, 0, 0, 255));
    step("clr_02", mk(8'h02, 0, 1, 0, 0, 0, 0, 255));
    step("clr_04", mk(8'h04, 0, 2, 0, 0, 0, 0, 255));
    step("clr_08", mk(8'h08, 0, 3, 0, 0, 0, 0, 255));
    step("clr_10", mk(8'h10, 0, 4, 1, 1, 0, 0, 255));
    step("clr_err", mk(8'h00, 1, 4, 0, 0, 1, 0, 0));

    step("rl_01", mk(8'h01, 0, 0, 0, 0, 0, 0, 0));
    step("rl_02", mk(8'h02, 0, 1, 0, 0, 0, 0, 0));
    step("rl_04", mk(8'h04, 0, 2, 0, 0, 0, 0, 0));
    step("rl_08", mk(8'h08, 0, 3, 0, 0, 0, 0, 0));
    step("rl_10", mk(8'h10, 0, 4, 1, 1, 0, 0, 0));
    step("rl_00", mk(8'h00, 0, 4, 0, 0, 1, 0, 1));
    step("rl2_01", mk(8'h01, 0, 0, 0, 0, 0, 0, 1));
    step("rl2_02", mk(8'h02, 0, 1, 0, 0, 0, 0, 1));
    step("rl2_04", mk(8'h04, 0, 2, 0, 0, 0, 0, 1));
    step("rl2_08", mk(8'h08, 0, 3, 0, 0, 0, 0, 1));
    step("rl2_10", mk(8'h10, 0, 4, 1, 1, 0, 0, 1));

    // Asynchronous reset between edges while locked.
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", mk(8'h00, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #1;
    step("post_20", mk(8'h20, 0, 5, 0, 0, 0, 0, 0));
    step("post_40", mk(8'h40, 0, 6, 0, 0, 0, 0, 0));
    step("post_80", mk(8'h80, 0, 7, 0, 0, 0, 0, 0));
    step("post_01", mk(8'h01, 0, 0, 0, 0, 0, 0, 0));
    step("post_02", mk(8'h02, 0, 1, 1, 1, 0, 0, 0));

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
